wm8731_i2s_master: RTL and testbench

- Serial audio interface between the filter datapath and the WM8731 codec, with the codec in slave mode.
- Generates BCLK and a shared LRCK (used for both DACLRCK and ADCLRCK) from the codec clock.
- Serialises parallel stereo DAC samples onto DACDAT in I2S format.
- Deserialises ADCDAT into parallel stereo samples.
- Sits between top's codec clock domain and the AUD_* pins.

---
 rtl/wm8731_i2s_master.sv | 170 +++++++++++++++++
 tb/tb_wm8731_i2s_master.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_i2s_master.sv
// WM8731 I2S master: BCLK/LRCK generation, DAC serialiser, ADC deserialiser.
// The codec runs in slave mode; every register is on the clk_i rising edge.
module wm8731_i2s_master #(
    parameter int BCLK_DIV = 2,
    parameter int SLOT_W   = 32,
    parameter int DATA_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] dac_left_i,
    input  logic [DATA_W-1:0] dac_right_i,
    input  logic              dac_valid_i,
    output logic              dac_ready_o,
    output logic              dac_underrun_o,
    output logic [DATA_W-1:0] adc_left_o,
    output logic [DATA_W-1:0] adc_right_o,
    output logic              adc_valid_o,
    output logic              bclk_o,
    output logic              lrck_o,
    output logic              dacdat_o,
    input  logic              adcdat_i
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int POS_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * SLOT_W - 1);
    localparam logic [POS_W-1:0] L_FIRST  = POS_W'(1);
    localparam logic [POS_W-1:0] L_LAST   = POS_W'(DATA_W);
    localparam logic [POS_W-1:0] R_SLOT   = POS_W'(SLOT_W);
    localparam logic [POS_W-1:0] R_FIRST  = POS_W'(SLOT_W + 1);
    localparam logic [POS_W-1:0] R_LAST   = POS_W'(SLOT_W + DATA_W);

    logic [DIV_W-1:0]  div_cnt;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_nxt;
    logic              bclk_q;
    logic              lrck_q;
    logic              dacdat_q;
    logic              underrun_q;
    logic              tick;
    logic              rise;
    logic              fall;
    logic              wrap;
    logic              dac_l_win;
    logic              dac_r_win;
    logic              adc_l_win;
    logic              adc_r_win;

    logic [DATA_W-1:0] dac_l_sh;
    logic [DATA_W-1:0] dac_r_sh;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic              hold_full;
    logic              accept;

    logic [DATA_W-1:0] adc_l_sh;
    logic [DATA_W-1:0] adc_r_sh;
    logic [DATA_W-1:0] adc_left_q;
    logic [DATA_W-1:0] adc_right_q;
    logic              adc_valid_q;

    always_comb begin
        tick    = (div_cnt == DIV_LAST);
        rise    = tick && !bclk_o;
        fall    = tick && bclk_q;
        wrap    = fall && (pos == POS_LAST);
        pos_nxt = (pos == POS_LAST) ? '0 : pos + 1'b1;
        // DAC windows look at the position being entered, ADC at the current one
        dac_l_win = (pos_nxt >= L_FIRST) && (pos_nxt <= L_LAST);
        dac_r_win = (pos_nxt >= R_FIRST) && (pos_nxt <= R_LAST);
        adc_l_win = (pos >= L_FIRST) && (pos <= L_LAST);
        adc_r_win = (pos >= R_FIRST) && (pos <= R_LAST);
        accept    = dac_valid_i && !hold_full;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            bclk_q  <= 1'b0;
            pos     <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                bclk_q <= !bclk_q;
            end
            if (fall) begin
                pos <= pos_nxt;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lrck_q     <= 1'b0;
            dacdat_q   <= 1'b0;
            dac_l_sh   <= '0;
            dac_r_sh   <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (fall) begin
                lrck_q   <= (pos_nxt >= R_SLOT);
                dacdat_q <= 1'b0;
                if (wrap) begin
                    dac_l_sh   <= hold_full ? hold_l : '0;
                    dac_r_sh   <= hold_full ? hold_r : '0;
                    underrun_q <= !hold_full;
                end else if (dac_l_win) begin
                    dacdat_q <= dac_l_sh[DATA_W-1];
                    dac_l_sh <= {dac_l_sh[DATA_W-2:0], 1'b0};
                end else if (dac_r_win) begin
                    dacdat_q <= dac_r_sh[DATA_W-1];
                    dac_r_sh <= {dac_r_sh[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    // An accept can only happen while empty, so it always wins over the load
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
        end else begin
            if (accept) begin
                hold_l    <= dac_left_i;
                hold_r    <= dac_right_i;
                hold_full <= 1'b1;
            end else if (wrap) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adc_l_sh    <= '0;
            adc_r_sh    <= '0;
            adc_left_q  <= '0;
            adc_right_q <= '0;
            adc_valid_q <= 1'b0;
        end else begin
            adc_valid_q <= 1'b0;
            if (rise && adc_l_win) begin
                adc_l_sh <= {adc_l_sh[DATA_W-2:0], adcdat_i};
            end
            if (rise && adc_r_win) begin
                adc_r_sh <= {adc_r_sh[DATA_W-2:0], adcdat_i};
            end
            if (rise && (pos == R_LAST)) begin
                adc_left_q  <= adc_l_sh;
                adc_right_q <= {adc_r_sh[DATA_W-2:0], adcdat_i};
                adc_valid_q <= 1'b1;
            end
        end
    end

    assign bclk_o         = bclk_q;
    assign lrck_o         = lrck_q;
    assign dacdat_o       = dacdat_q;
    assign dac_ready_o    = !hold_full;
    assign dac_underrun_o = underrun_q;
    assign adc_left_o     = adc_left_q;
    assign adc_right_o    = adc_right_q;
    assign adc_valid_o    = adc_valid_q;

endmodule

// File: tb/tb_wm8731_i2s_master.sv
// Bench for wm8731_i2s_master: frame-level reference model of the I2S
// stream, checked against BCLK-rise samples of DACDAT/LRCK and ADC pairs.
module tb_wm8731_i2s_master;

    localparam int BCLK_DIV  = 2;
    localparam int SLOT_W    = 32;
    localparam int DATA_W    = 16;
    localparam int FBITS     = 2 * SLOT_W;
    localparam int FRAME_CLK = 2 * BCLK_DIV * FBITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] dac_left = '0;
    logic [DATA_W-1:0] dac_right = '0;
    logic              dac_valid = 1'b0;
    logic              dac_ready;
    logic              dac_underrun;
    logic [DATA_W-1:0] adc_left;
    logic [DATA_W-1:0] adc_right;
    logic              adc_valid;
    logic              bclk;
    logic              lrck;
    logic              dacdat;
    logic              adcdat;
    logic              loop_en = 1'b0;
    logic              adc_rnd = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    wm8731_i2s_master #(
        .BCLK_DIV(BCLK_DIV),
        .SLOT_W  (SLOT_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dac_left_i    (dac_left),
        .dac_right_i   (dac_right),
        .dac_valid_i   (dac_valid),
        .dac_ready_o   (dac_ready),
        .dac_underrun_o(dac_underrun),
        .adc_left_o    (adc_left),
        .adc_right_o   (adc_right),
        .adc_valid_o   (adc_valid),
        .bclk_o        (bclk),
        .lrck_o        (lrck),
        .dacdat_o      (dacdat),
        .adcdat_i      (adcdat)
    );

    always #5 clk = ~clk;

    // Codec side: new ADC bit after each BCLK fall
    always @(negedge bclk) adc_rnd <= 1'($urandom);
    assign adcdat = loop_en ? dacdat : adc_rnd;

    // Frame collector (no checking here)
    int cyc;
    int rise_cnt;
    int p;
    logic prev_bclk;
    logic [FBITS-1:0] cur_dac, cur_lr, cur_adc;
    logic [FBITS-1:0] dac_q[$];
    logic [FBITS-1:0] lr_q[$];
    logic [FBITS-1:0] adcb_q[$];
    logic [2*DATA_W-1:0] adc_q[$];
    logic [2*DATA_W-1:0] src_q[$];
    int adcf_q[$];
    int und_q[$];
    int acc_q[$];

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
            rise_cnt = 0;
            prev_bclk = 1'b0;
        end else begin
            cyc++;
            if (bclk && !prev_bclk) begin
                p = rise_cnt % FBITS;
                cur_dac[FBITS-1-p] = dacdat;
                cur_lr[FBITS-1-p]  = lrck;
                cur_adc[FBITS-1-p] = adcdat;
                if (p == FBITS - 1) begin
                    dac_q.push_back(cur_dac);
                    lr_q.push_back(cur_lr);
                    adcb_q.push_back(cur_adc);
                end
                rise_cnt++;
            end
            prev_bclk = bclk;
            if (dac_underrun) und_q.push_back(rise_cnt / FBITS);
            if (adc_valid) begin
                adc_q.push_back({adc_left, adc_right});
                adcf_q.push_back(rise_cnt / FBITS);
            end
            if (dac_valid && dac_ready) acc_q.push_back(cyc);
        end
    end

    // Expected DACDAT frame: one-BCLK-delayed MSB-first slots, zeros elsewhere
    function automatic logic [FBITS-1:0] frame_bits(input logic [2*DATA_W-1:0] pr);
        logic [FBITS-1:0] v;
        logic [DATA_W-1:0] l, r;
        l = pr[2*DATA_W-1:DATA_W];
        r = pr[DATA_W-1:0];
        v = '0;
        for (int i = 1; i <= DATA_W; i++) begin
            v[FBITS-1-i]          = l[DATA_W-i];
            v[FBITS-1-(SLOT_W+i)] = r[DATA_W-i];
        end
        return v;
    endfunction

    function automatic logic [FBITS-1:0] lr_bits();
        logic [FBITS-1:0] v;
        for (int i = 0; i < FBITS; i++) v[FBITS-1-i] = (i >= SLOT_W);
        return v;
    endfunction

    function automatic logic [2*DATA_W-1:0] adc_pair(input logic [FBITS-1:0] v);
        logic [DATA_W-1:0] l, r;
        for (int i = 1; i <= DATA_W; i++) begin
            l[DATA_W-i] = v[FBITS-1-i];
            r[DATA_W-i] = v[FBITS-1-(SLOT_W+i)];
        end
        return {l, r};
    endfunction

    task automatic clear_q();
        dac_q.delete();
        lr_q.delete();
        adcb_q.delete();
        adc_q.delete();
        adcf_q.delete();
        und_q.delete();
        acc_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dac_valid = 1'b0;
        repeat (3) @(negedge clk);
        clear_q();
        #1 rst = 1'b0;
    endtask

    // Source that holds valid and advances only on a handshake
    task automatic feed(input int nframes, input int stop_rise, output bit timeout);
        int idx = 0;
        int n = 0;
        bit pend;
        timeout = 1'b0;
        while (dac_q.size() < nframes && rise_cnt < stop_rise) begin
            if (n++ > (nframes + 4) * FRAME_CLK) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            #1 pend = dac_valid && dac_ready;
            @(posedge clk);
            #1;
            if (pend) idx++;
            if (idx < src_q.size()) begin
                dac_valid = 1'b1;
                {dac_left, dac_right} = src_q[idx];
            end else begin
                dac_valid = 1'b0;
            end
        end
        dac_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [2*DATA_W+6:0] got;
        repeat (2) @(negedge clk);
        #1;
        got = {bclk, lrck, dacdat, dac_ready, dac_underrun, adc_valid, adc_left, adc_right, 1'b0};
        n_cmp++;
        if (got !== {6'b000100, {2*DATA_W{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", got, {6'b000100, {2*DATA_W{1'b0}}, 1'b0});
        end
    endtask

    task automatic test_clocks();
        logic pb, pl;
        do_reset();
        pb = 1'b0;
        pl = 1'b0;
        for (int c = 1; c <= 2 * FRAME_CLK; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (bclk !== 1'((c / BCLK_DIV) % 2)) begin
                n_fail++;
                $display("FAIL bclk_cycle%0d: got %b expected %b", c, bclk, 1'((c / BCLK_DIV) % 2));
            end
            n_cmp++;
            if (lrck !== 1'((c / (FRAME_CLK / 2)) % 2)) begin
                n_fail++;
                $display("FAIL lrck_cycle%0d: got %b expected %b", c, lrck, 1'((c / (FRAME_CLK / 2)) % 2));
            end
            if (lrck !== pl) begin
                n_cmp++;
                if ({pb, bclk} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL lrck_on_bclk_fall cycle%0d: got bclk %b->%b expected 1->0", c, pb, bclk);
                end
            end
            pb = bclk;
            pl = lrck;
        end
    endtask

    task automatic test_dac_serial();
        bit to;
        do_reset();
        src_q = '{{16'hA5C3, 16'h8001}};
        feed(2, 1 << 30, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL dac_serial_timeout: got %0d frames expected 2", dac_q.size());
        end else begin
            n_cmp += 4;
            if (dac_q[0] !== '0) begin
                n_fail++;
                $display("FAIL dac_frame0: got %h expected 0", dac_q[0]);
            end
            if (dac_q[1] !== frame_bits(src_q[0])) begin
                n_fail++;
                $display("FAIL dac_frame1: got %h expected %h", dac_q[1], frame_bits(src_q[0]));
            end
            if (lr_q[1] !== lr_bits()) begin
                n_fail++;
                $display("FAIL lrck_frame1: got %h expected %h", lr_q[1], lr_bits());
            end
            if (und_q.size() != 0) begin
                n_fail++;
                $display("FAIL dac_no_underrun: got %0d pulses expected 0", und_q.size());
            end
        end
    endtask

    task automatic test_loopback();
        bit to;
        do_reset();
        loop_en = 1'b1;
        src_q = '{{16'h1234, 16'hFEDC}};
        repeat (4) src_q.push_back($urandom);
        feed(6, 1 << 30, to);
        loop_en = 1'b0;
        n_cmp++;
        if (to || adc_q.size() != 6) begin
            n_fail++;
            $display("FAIL loop_count: got %0d pairs expected 6", adc_q.size());
        end else begin
            for (int f = 0; f < 6; f++) begin
                n_cmp += 2;
                if (adcf_q[f] != f) begin
                    n_fail++;
                    $display("FAIL loop_frame_idx%0d: got %0d expected %0d", f, adcf_q[f], f);
                end
                if (adc_q[f] !== ((f == 0) ? '0 : src_q[f-1])) begin
                    n_fail++;
                    $display("FAIL loop_pair%0d: got %h expected %h", f, adc_q[f],
                             (f == 0) ? '0 : src_q[f-1]);
                end
            end
        end
    endtask

    task automatic test_underrun();
        bit to;
        do_reset();
        src_q = '{32'($urandom)};
        feed(3, 1 << 30, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL underrun_timeout: got %0d frames expected 3", dac_q.size());
        end else begin
            n_cmp += 3;
            if (dac_q[1] !== frame_bits(src_q[0])) begin
                n_fail++;
                $display("FAIL underrun_frame1: got %h expected %h", dac_q[1], frame_bits(src_q[0]));
            end
            if (dac_q[2] !== '0) begin
                n_fail++;
                $display("FAIL underrun_frame2: got %h expected 0", dac_q[2]);
            end
            if (und_q.size() != 1 || und_q[0] != 2) begin
                n_fail++;
                $display("FAIL underrun_pulse: got %0d pulses (first frame %0d) expected 1 at frame 2",
                         und_q.size(), (und_q.size() > 0) ? und_q[0] : -1);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [DATA_W-1:0] bl, br;
        do_reset();
        bl = DATA_W'($urandom);
        br = DATA_W'($urandom);
        src_q.delete();
        for (int k = 0; k < 5; k++) src_q.push_back({bl + DATA_W'(k), br + DATA_W'(k)});
        feed(6, 1 << 30, to);
        n_cmp++;
        if (to || acc_q.size() != 5) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d expected 5", acc_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp += 2;
                if (acc_q[k] != ((k == 0) ? 2 : k * FRAME_CLK)) begin
                    n_fail++;
                    $display("FAIL b2b_accept_cycle%0d: got %0d expected %0d", k, acc_q[k],
                             (k == 0) ? 2 : k * FRAME_CLK);
                end
                if (dac_q[k+1] !== frame_bits(src_q[k])) begin
                    n_fail++;
                    $display("FAIL b2b_frame%0d: got %h expected %h", k + 1, dac_q[k+1],
                             frame_bits(src_q[k]));
                end
            end
            n_cmp++;
            if (und_q.size() != 0) begin
                n_fail++;
                $display("FAIL b2b_underrun: got %0d pulses expected 0", und_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [2*DATA_W+5:0] got;
        do_reset();
        src_q = '{32'($urandom), 32'($urandom)};
        feed(1 << 20, FBITS + 21, to);
        n_cmp += 2;
        if (to || adc_q.size() != 1 || acc_q.size() != 2) begin
            n_fail++;
            $display("FAIL mid_setup: got %0d pairs %0d accepts expected 1 and 2", adc_q.size(), acc_q.size());
        end else if (adc_q[0] !== adc_pair(adcb_q[0])) begin
            n_fail++;
            $display("FAIL adc_frame0: got %h expected %h", adc_q[0], adc_pair(adcb_q[0]));
        end
        rst = 1'b1;
        #1;
        got = {bclk, lrck, dacdat, dac_ready, dac_underrun, adc_valid, adc_left, adc_right};
        n_cmp++;
        if (got !== {6'b000100, {2*DATA_W{1'b0}}}) begin
            n_fail++;
            $display("FAIL mid_async_reset: got %h expected %h", got, {6'b000100, {2*DATA_W{1'b0}}});
        end
        repeat (3) @(negedge clk);
        clear_q();
        src_q.delete();
        #1 rst = 1'b0;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            #1;
            if (c <= 8) begin
                n_cmp++;
                if (bclk !== 1'((c / BCLK_DIV) % 2)) begin
                    n_fail++;
                    $display("FAIL mid_bclk_cycle%0d: got %b expected %b", c, bclk, 1'((c / BCLK_DIV) % 2));
                end
            end
            if (c == FRAME_CLK / 2 - 1 || c == FRAME_CLK / 2) begin
                n_cmp++;
                if (lrck !== 1'(c == FRAME_CLK / 2)) begin
                    n_fail++;
                    $display("FAIL mid_lrck_cycle%0d: got %b expected %b", c, lrck, 1'(c == FRAME_CLK / 2));
                end
            end
        end
        n_cmp++;
        if (adc_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_aborted_adc: got %0d pulses expected 0", adc_q.size());
        end
        feed(2, 1 << 30, to);
        n_cmp++;
        if (to || dac_q[0] !== '0 || dac_q[1] !== '0 || und_q.size() != 1 || und_q[0] != 1
            || adc_q.size() != 2 || adcf_q[0] != 0) begin
            n_fail++;
            $display("FAIL mid_restart: got frames %0d und %0d adc %0d expected silent 2 frames, 1 underrun, 2 pairs",
                     dac_q.size(), und_q.size(), adc_q.size());
        end else begin
            n_cmp++;
            if (adc_q[0] !== adc_pair(adcb_q[0])) begin
                n_fail++;
                $display("FAIL mid_adc_pair: got %h expected %h", adc_q[0], adc_pair(adcb_q[0]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_dac_serial();
        test_loopback();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
